// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO and sends them LSB-first with start/stop bits.
// Optional even-parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int bits_per_word = 8,
    parameter int clks_per_bit  = 16
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     enable,
    input  logic [bits_per_word-1:0] fifo_read_data,
    input  logic                     fifo_empty,
    output logic                     fifo_read,
    output logic                     tx,
    output logic                     busy
);

    localparam int CW = $clog2(clks_per_bit);
    localparam int IW = $clog2(bits_per_word);
    localparam logic [CW-1:0] BAUD_LAST = CW'(clks_per_bit - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(bits_per_word - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [bits_per_word-1:0] word);
        return ^word;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t                   state_r, state_s;
    logic [CW-1:0]            baud_r, baud_s;
    logic [IW-1:0]            bit_r, bit_s;
    logic [bits_per_word-1:0] shift_r, shift_s;
    logic                     tx_r, tx_s;
    logic                     busy_r;
    logic                     pop_s;
    logic                     bit_end_s;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                     parity_r, parity_s;
`endif

    assign bit_end_s = (baud_r == BAUD_LAST);
    assign fifo_read = pop_s & areset_n;
    assign tx        = tx_r;
    assign busy      = busy_r;

    // Next-state, datapath and next-line-level logic
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        tx_s    = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_read_data;
                    bit_s   = {IW{1'b0}};
                    baud_s  = {CW{1'b0}};
                    state_s = START;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_s = even_parity(fifo_read_data);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_s  = {CW{1'b0}};
                    state_s = DATA;
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_s = {CW{1'b0}};
                    if (bit_r == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        shift_s = shift_r >> 1;
                        bit_s   = bit_r + IW'(1);
                    end
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    baud_s  = {CW{1'b0}};
                    state_s = STOP;
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    baud_s  = {CW{1'b0}};
                    state_s = IDLE;
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = {CW{1'b0}};
            end
        endcase

        // The line level follows the state being entered so tx is a clean register.
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_s = parity_s;
`endif
            default: tx_s = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state_r <= IDLE;
            baud_r  <= {CW{1'b0}};
            bit_r   <= {IW{1'b0}};
            shift_r <= {bits_per_word{1'b0}};
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            busy_r  <= (state_s != IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, per-cycle line-waveform reference and
// directed plus random scenarios.
module tb_fifo_uart_tx;

    localparam int BPW = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB         = BPW + 3;
    localparam int PERIOD_LIT = 45;
    localparam int PAR_A5     = 0;
    localparam int PAR_07     = 1;
`else
    localparam int NB         = BPW + 2;
    localparam int PERIOD_LIT = 41;
    localparam int PAR_A5     = 1;
    localparam int PAR_07     = 1;
`endif
    localparam int F = NB * CPB;

    logic           clk = 1'b0;
    logic           areset_n;
    logic           enable;
    logic [BPW-1:0] fifo_read_data;
    logic           fifo_empty;
    logic           fifo_read;
    logic           tx;
    logic           busy;

    fifo_uart_tx #(.bits_per_word(BPW), .clks_per_bit(CPB)) dut (
        .clk(clk), .areset_n(areset_n), .enable(enable),
        .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // FIFO model
    logic [BPW-1:0] fq[$];

    task automatic fifo_update();
        if (fq.size() == 0) begin
            fifo_empty     = 1'b1;
            fifo_read_data = BPW'($urandom);
        end else begin
            fifo_empty     = 1'b0;
            fifo_read_data = fq[0];
        end
    endtask

    task automatic push(input logic [BPW-1:0] w);
        fq.push_back(w);
        fifo_update();
    endtask

    initial begin : drv
        logic rd;
        forever begin
            @(negedge clk);
            rd = fifo_read;
            @(posedge clk);
            #1;
            if (rd && fq.size() > 0) void'(fq.pop_front());
            fifo_update();
        end
    end

    // Reference model: each observed pop schedules the full expected line waveform
    logic           exp_q[$];
    int             pop_cyc[$];
    logic [BPW-1:0] pop_word[$];
    logic           tx_log [0:8191];

    initial begin : cmp
        logic           exp_tx, exp_busy, exp_rd;
        logic [BPW-1:0] w;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_tx   = exp_q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
            exp_rd = !exp_busy && enable && !fifo_empty && areset_n;
            check("tx", {31'd0, tx}, {31'd0, exp_tx});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("fifo_read", {31'd0, fifo_read}, {31'd0, exp_rd});
            tx_log[cyc % 8192] = tx;
            if (!areset_n) begin
                exp_q.delete();
            end else if (fifo_read) begin
                w = fifo_read_data;
                pop_cyc.push_back(cyc);
                pop_word.push_back(w);
                for (int j = 0; j < CPB; j++) exp_q.push_back(1'b0);
                for (int k = 0; k < BPW; k++)
                    for (int j = 0; j < CPB; j++) exp_q.push_back(w[k]);
`ifdef FIFO_UART_TX_PARITY_EN
                for (int j = 0; j < CPB; j++) exp_q.push_back(^w);
`endif
                for (int j = 0; j < CPB; j++) exp_q.push_back(1'b1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int i = 0;
        while (pop_cyc.size() < n && i < budget) begin
            step(1);
            i++;
        end
        check("pop_wait", pop_cyc.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((fq.size() != 0 || busy !== 1'b0) && i < budget) begin
            step(1);
            i++;
        end
        check("drain_fifo", fq.size(), 0);
        check("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic log_at(input int c);
        return tx_log[c % 8192];
    endfunction

    initial begin : main
        int t;
        int e;
        int lit[$];
        areset_n = 1'b0;
        enable   = 1'b1;
        fifo_update();
        step(3);
        areset_n = 1'b1;

        // Empty FIFO: nothing happens
        step(100);
        check("idle_pops", pop_cyc.size(), 0);
        check("idle_tx", {31'd0, tx}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single word 0xA5
        push(8'hA5);
        wait_pops(1, 20);
        t = pop_cyc[0];
        while (cyc < t + F + 3) step(1);
`ifdef FIFO_UART_TX_PARITY_EN
        lit = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        lit = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < CPB; j++)
                check("a5_bit", {31'd0, log_at(t + 1 + k * CPB + j)}, lit[k]);
        check("a5_after", {31'd0, log_at(t + F + 1)}, 32'd1);
        check("a5_one_pop", pop_cyc.size(), 1);

        // Back-to-back 0x01, 0x80
        push(8'h01);
        push(8'h80);
        wait_pops(3, 2 * F + 20);
        check("b2b_spacing", pop_cyc[2] - pop_cyc[1], PERIOD_LIT);
        check("b2b_stop_end", {31'd0, log_at(pop_cyc[2] - 1)}, 32'd1);
        check("b2b_idle", {31'd0, log_at(pop_cyc[2])}, 32'd1);
        wait_idle(2 * F + 20);
        check("b2b_start2", {31'd0, log_at(pop_cyc[2] + 1)}, 32'd0);

        // Parity slot for 0xA5 and 0x07
        push(8'hA5);
        push(8'h07);
        wait_pops(5, 2 * F + 20);
        wait_idle(2 * F + 20);
        check("par_a5", {31'd0, log_at(pop_cyc[3] + 1 + 9 * CPB)}, PAR_A5);
        check("par_07", {31'd0, log_at(pop_cyc[4] + 1 + 9 * CPB)}, PAR_07);
        check("par_period", pop_cyc[4] - pop_cyc[3], PERIOD_LIT);

        // Enable dropped mid-frame
        push(8'h3C);
        push(8'h55);
        wait_pops(6, 20);
        t = pop_cyc[5];
        while (cyc < t + 1 + 4 * CPB) step(1);
        enable = 1'b0;
        step(F + 20);
        check("en_no_pop", pop_cyc.size(), 6);
        check("en_word0", pop_word[5], 32'h3C);
        e = cyc;
        enable = 1'b1;
        wait_pops(7, 20);
        check("en_resume_cycle", pop_cyc[6], e);
        check("en_word1", pop_word[6], 32'h55);
        wait_idle(F + 20);

        // Reset pulse during data bit 5
        push(8'h11);
        push(8'h22);
        wait_pops(8, 20);
        t = pop_cyc[7];
        while (cyc < t + 2 + 6 * CPB) step(1);
        areset_n = 1'b0;
        step(1);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        areset_n = 1'b1;
        wait_pops(9, 20);
        check("rst_next_word", pop_word[8], 32'h22);
        wait_idle(F + 20);

        // Random words with random enable pattern
        for (int i = 0; i < 8; i++) push(BPW'($urandom));
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) push(BPW'($urandom));
            step(1);
        end
        enable = 1'b1;
        wait_idle(20 * (F + 1) + 100);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the `fifo` buffer and sends each word as an asynchronous UART frame. It connects directly to the FIFO read side (`read`, `read_data`, `empty`) and pops one word per frame. It serializes the word LSB-first with start and stop bits at a fixed baud divisor. It is the downstream consumer that turns buffered words into a line-level output.

## Interface
Parameters:
- `bits_per_word`, default 8: data bits per frame; must match the FIFO word width; legal range 5–9.
- `clks_per_bit`, default 16: clock cycles per serial bit; legal range ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `areset_n`  in  1  reset; synchronous, active-low.
- `enable`  in  1  allows new frames to start; sampled in IDLE only.
- `fifo_read_data`  in  `bits_per_word`  FIFO head word; valid whenever `fifo_empty` = 0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read`  out  1  pop strobe to the FIFO `read` input.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  high while a frame is in progress; registered.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `fifo_read` is combinational: 1 exactly when state = IDLE, `enable` = 1 and `fifo_empty` = 0.
  - In that cycle, `fifo_read_data` is loaded into the shift register and the bit counter is cleared.
  - The next state is START.
- START: `tx` = 0 for `clks_per_bit` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0; the register shifts right once per bit period.
  - A bit index counts 0..`bits_per_word`-1.
  - After the last bit, go to PARITY (macro defined) or STOP.
- STOP: `tx` = 1 for `clks_per_bit` cycles, then go to IDLE.
- Baud counter:
  - Width $clog2(`clks_per_bit`).
  - Counts 0..`clks_per_bit`-1 and wraps to 0 at each bit boundary, where the state/bit index advances.
  - Cleared on entry to START.
- `busy` = 1 in every state except IDLE.
- `enable` dropped mid-frame: the current frame completes normally; no new pop happens until `enable` returns.
- `fifo_empty` is ignored outside IDLE.
- The block never pops when `fifo_empty` = 1. Underflow is impossible by construction.
- Reset:
  - `areset_n` = 0 at a rising edge forces state IDLE, `tx` = 1, `busy` = 0, and clears the counters and shift register.
  - `fifo_read` is 0 while `areset_n` = 0.
  - A word popped before a mid-frame reset is lost; this is acceptable.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `fifo_read` = 0.
- Pop in cycle T:
  - `tx` falls and `busy` rises at the edge ending cycle T.
  - The start bit occupies cycles T+1 .. T+`clks_per_bit`.
- Data bit k occupies cycles T+1+(k+1)·`clks_per_bit` .. T+(k+2)·`clks_per_bit`.
- Frame length F = (2 + `bits_per_word` [+1 with parity]) · `clks_per_bit` cycles.
- Back-to-back frames:
  - The state spends exactly one cycle in IDLE between frames (`tx` = 1, `busy` = 0).
  - The next pop occurs in that cycle, so the frame period is F + 1 cycles.
- Exactly one `fifo_read` pulse (1 cycle) per frame.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is inserted between DATA and STOP for one bit period.
  - `tx` = even parity, the XOR of all `bits_per_word` data bits, computed from the word captured at pop.
- Undefined:
  - No PARITY state, no parity logic.
  - The frame is start + data + stop.

## Test plan
- Reset with `clks_per_bit`=4, `bits_per_word`=8, FIFO empty, `enable`=1 for 100 cycles -> `tx`=1, `busy`=0, `fifo_read` never asserted.
- Single word 0xA5, no parity -> one `fifo_read` pulse. `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total), then `busy`=0.
- Words 0x01 and 0x80 queued -> two pops, 41 cycles apart. Exactly 1 idle-high cycle between the first stop bit and the second start bit.
- With `FIFO_UART_TX_PARITY_EN`, words 0xA5 then 0x07 -> parity bits 0 and 1 respectively, each frame 44 cycles.
- `enable` dropped at data bit 3 of 0x3C with 0x55 still queued -> 0x3C frame completes intact. No pop while `enable`=0. 0x55 is sent 1 cycle after `enable` returns high.
- `areset_n` pulsed low for 1 cycle during data bit 5 -> `tx`=1 and `busy`=0 on the next edge. The next queued word is sent as a clean full frame.
